// File: rtl/reg_bank_vhdl_pkg.sv
// ============================================================================
// Module   : reg_bank_pkg
// Brief    : Shared defaults for the reg_bank_vhdl register bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns / 1ps

package reg_bank_pkg;

    localparam int c_default_width = 4;
    localparam logic [c_default_width-1:0] c_default_reset_value = '0;

endpackage : reg_bank_pkg

`default_nettype wire

// File: rtl/reg_bank_vhdl_if.sv
// ============================================================================
// Module   : reg_bank_vhdl_if
// Brief    : Data bundle (d in, q out) for hooking a reg_bank_vhdl into a bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns / 1ps

interface reg_bank_vhdl_if #(
    parameter int WIDTH = reg_bank_pkg::c_default_width
);

    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    modport master (output d, input  q);
    modport slave  (input  d, output q);

endinterface : reg_bank_vhdl_if

`default_nettype wire

// File: rtl/reg_bank_vhdl_bit.sv
// ============================================================================
// Module   : reg_bank_bit
// Brief    : 1-bit D flop, rising clk, asynchronous active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns / 1ps

module reg_bank_bit #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  wire logic d,
    input  wire logic clk,
    input  wire logic reset,
    output logic      q
);

    logic r_q;

    // An X/Z reset makes !reset unknown, so the else branch captures d.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= RESET_VALUE;
        end else begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule : reg_bank_bit

`default_nettype wire

// File: rtl/reg_bank_vhdl.sv
// ============================================================================
// Module   : reg_bank_vhdl
// Brief    : WIDTH-bit D register bank built from per-bit async-reset flops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns / 1ps

module reg_bank_vhdl
    import reg_bank_pkg::*;
#(
    parameter int               WIDTH       = c_default_width,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(c_default_reset_value)
) (
    input  wire logic [WIDTH-1:0] d,
    input  wire logic             clk,
    input  wire logic             reset,
    output logic      [WIDTH-1:0] q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        reg_bank_bit #(
            .RESET_VALUE (RESET_VALUE[i])
        ) u_bit (
            .d     (d[i]),
            .clk   (clk),
            .reset (reset),
            .q     (q[i])
        );
    end

endmodule : reg_bank_vhdl

`default_nettype wire

// File: tb/tb_reg_bank_vhdl.sv
// ============================================================================
// Module   : tb_reg_bank_vhdl
// Brief    : Directed and random checks of reg_bank_vhdl against expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns / 1ps

module tb_reg_bank_vhdl;

    localparam int c_width = 4;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    bit   four_state;
    logic probe;
    logic [c_width-1:0] ref_q;

    reg_bank_vhdl_if #(.WIDTH(c_width)) bus ();

    reg_bank_vhdl #(
        .WIDTH (c_width)
    ) dut (
        .d     (bus.d),
        .clk   (clk),
        .reset (reset),
        .q     (bus.q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference flop: reset only when reset is exactly 0.
    always @(posedge clk or negedge reset) begin
        ref_q <= (reset === 1'b0) ? 4'b0000 : bus.d;
    end

    task automatic check(input string tag, input logic [c_width-1:0] got,
                         input logic [c_width-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: q=%b expected %b", tag, $time, got, exp);
        end
    endtask

    task automatic wait_until(input realtime t);
        if (t > $realtime) #(t - $realtime);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        probe   = 1'bx;
        four_state = $isunknown(probe);
        bus.d   = 4'b1010;

        // Power-up: no event yet, q must still be unknown
        wait_until(0.5);
        if (four_state) check("power_up_x", bus.q, 4'bxxxx);

        wait_until(1);   reset = 1'b0;
        wait_until(2);   check("reset_immediate", bus.q, 4'b0000);
        wait_until(6);   check("reset_clk1", bus.q, 4'b0000);
        wait_until(16);  check("reset_clk2", bus.q, 4'b0000);

        wait_until(18);  reset = 1'b1;
        wait_until(19);  check("deassert_no_change", bus.q, 4'b0000);
        wait_until(26);  check("capture_1010", bus.q, 4'b1010);
        wait_until(28);  bus.d = 4'b0101;
        wait_until(30);  check("hold_mid_cycle", bus.q, 4'b1010);
        wait_until(36);  check("capture_0101", bus.q, 4'b0101);

        wait_until(38);  bus.d = 4'b1111;
        wait_until(46);  check("capture_1111", bus.q, 4'b1111);
        wait_until(48);  reset = 1'b0;
        wait_until(48.5); check("async_assert", bus.q, 4'b0000);
        wait_until(56);  check("reset_ignores_clk", bus.q, 4'b0000);

        wait_until(58);  reset = 1'b1; bus.d = 4'b0110;
        wait_until(58.5); check("deassert_hold", bus.q, 4'b0000);

        if (four_state) begin
            wait_until(59);  reset = 1'bx;
            wait_until(60);  check("x_fall_loads_d", bus.q, 4'b0110);
            wait_until(62);  bus.d = 4'b0011;
            wait_until(66);  check("x_reset_clk", bus.q, 4'b0011);
            wait_until(68);  reset = 1'b1;
            wait_until(70);  bus.d = 4'b1x0x;
            wait_until(76);  check("x_data_passthru", bus.q, 4'b1x0x);
        end

        // Reset falling on the very same step as a rising clk edge
        wait_until(78);  reset = 1'b1; bus.d = 4'b1001;
        wait_until(85);  reset = 1'b0;
        wait_until(86);  check("simultaneous_edge", bus.q, 4'b0000);
        wait_until(88);  reset = 1'b1;
        wait_until(96);  check("resume_1001", bus.q, 4'b1001);

        // Random regression; fractional offsets keep stimulus off clk edges
        fork
            begin
                wait_until(100.1);
                repeat (20000) begin
                    check("random_vs_ref", bus.q, ref_q);
                    #5;
                end
            end
            begin
                wait_until(100.3);
                repeat (33334) begin
                    bus.d = 4'($urandom_range(0, 15));
                    if (four_state && $urandom_range(0, 3) == 0)
                        bus.d[$urandom_range(0, 3)] = 1'bx;
                    #3;
                end
            end
            begin
                wait_until(100.6);
                repeat (4348) begin
                    case ($urandom_range(0, 2))
                        0:       reset = 1'b0;
                        1:       reset = 1'b1;
                        default: reset = 1'bx;
                    endcase
                    #23;
                end
            end
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_reg_bank_vhdl

`default_nettype wire
